// File: rtl/ws_frame_sequencer.sv
// ws_frame_sequencer: WS2812 frame scheduler for one LED chain.
// On each refresh tick it snapshots every pixel colour and the brightness,
// streams brightness-scaled GRB words to the bit serializer over a
// valid/ready handshake, waits for the serializer to drain, then holds
// the line idle for the latch gap before the next frame may start.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   enable       allows new frames to start; a frame in flight always completes
//   pix_in       NUM_PIX packed {R,G,B} words, pixel k at [24k+23:24k]
//   bright       global brightness, sampled when a frame is loaded
//   px_valid     px_data holds a word for the serializer
//   px_data      scaled pixel word in {G,R,B} order
//   px_ready     serializer accepts px_data this cycle
//   ser_busy     serializer still shifting out bits
//   busy         sequencer is in any state other than IDLE
//   frame_done   one-cycle pulse after the latch gap
module ws_frame_sequencer #(
    parameter int unsigned NUM_PIX        = 7,
    parameter int unsigned REFRESH_CYCLES = 400000,
    parameter int unsigned LATCH_CYCLES   = 1200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [24*NUM_PIX-1:0]   pix_in,
    input  logic [7:0]              bright,
    output logic                    px_valid,
    output logic [23:0]             px_data,
    input  logic                    px_ready,
    input  logic                    ser_busy,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIX - 1);
    localparam logic [REF_W-1:0] REF_MAX  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        DRAIN,
        LATCH
    } state_t;

    state_t           state;
    logic [REF_W-1:0] ref_cnt;
    logic             tick_c;
    logic             pending;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx_c;
    logic [LAT_W-1:0] lat_cnt;
    logic [7:0]       br_q;
    logic [23:0]      fb [NUM_PIX];

    // Scale each channel by (bright+1)/256 and reorder {R,G,B} -> {G,R,B}.
    function automatic logic [23:0] scale(input logic [23:0] rgb, input logic [7:0] b);
        logic [15:0] k;
        logic [15:0] pr;
        logic [15:0] pg;
        logic [15:0] pb;
        k  = 16'(b) + 16'd1;
        pr = 16'(rgb[23:16]) * k;
        pg = 16'(rgb[15:8])  * k;
        pb = 16'(rgb[7:0])   * k;
        return {pg[15:8], pr[15:8], pb[15:8]};
    endfunction

    assign tick_c   = (ref_cnt == REF_MAX);
    assign idx_nx_c = idx + IDX_W'(1);

    // Free-running frame-period counter, independent of enable and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= tick_c ? '0 : ref_cnt + REF_W'(1);
        end
    end

    // Frame snapshot; only meaningful once a LOAD has happened, so no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int k = 0; k < NUM_PIX; k++) begin
                fb[k] <= pix_in[24*k +: 24];
            end
        end
    end

    // Frame sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            px_valid   <= 1'b0;
            px_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            idx        <= '0;
            lat_cnt    <= '0;
            br_q       <= '0;
        end else begin
            frame_done <= 1'b0;
            // Ticks that cannot start a frame right away collapse into one request.
            if (tick_c && ((state != IDLE) || !enable)) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable && (tick_c || pending)) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                LOAD: begin
                    idx      <= '0;
                    br_q     <= bright;
                    px_data  <= scale(pix_in[23:0], bright);
                    px_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (px_ready) begin
                        if (idx == IDX_LAST) begin
                            px_valid <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            idx     <= idx_nx_c;
                            px_data <= scale(fb[idx_nx_c], br_q);
                        end
                    end
                end
                DRAIN: begin
                    if (!ser_busy) begin
                        lat_cnt <= '0;
                        state   <= LATCH;
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAT_MAX) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Testbench for ws_frame_sequencer: directed frames with hand-computed
// expected pixel words pushed into a scoreboard queue; a negedge monitor
// pops and compares on every handshake and records frame timing events.
module tb_ws_frame_sequencer;

    localparam int NP = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [24*NP-1:0] pix_in;
    logic [7:0]       bright;
    logic             px_valid;
    logic [23:0]      px_data;
    logic             px_ready;
    logic             ser_busy;
    logic             busy;
    logic             frame_done;

    always #5 clk = ~clk;

    ws_frame_sequencer #(
        .NUM_PIX        (NP),
        .REFRESH_CYCLES (1000),
        .LATCH_CYCLES   (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pix_in     (pix_in),
        .bright     (bright),
        .px_valid   (px_valid),
        .px_data    (px_data),
        .px_ready   (px_ready),
        .ser_busy   (ser_busy),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [23:0] sb_q [$];
    logic [23:0] set_tab [2][NP];
    logic [23:0] exp_tab [4][NP];
    int          hs_total = 0;
    int          rise_count = 0;
    int          fd_count = 0;
    int          rise_cyc = 0;
    int          fd_cyc = 0;
    logic        busy_prev = 1'b0;
    logic        fd_prev = 1'b0;
    logic        hold_pend = 1'b0;
    logic [23:0] hold_data = '0;
    int          bp_mode = 0;
    int          bp_ph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on handshake, hold stability, timing events.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
            busy_prev = 1'b0;
            fd_prev   = 1'b0;
        end else begin
            if (hold_pend && px_valid) chk("hold_stable", 32'(px_data), 32'(hold_data));
            if (px_valid && px_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h required no word", px_data);
                end else begin
                    chk("px_data", 32'(px_data), 32'(sb_q.pop_front()));
                end
                hs_total++;
                hold_pend = 1'b0;
            end else if (px_valid) begin
                hold_pend = 1'b1;
                hold_data = px_data;
            end else begin
                hold_pend = 1'b0;
            end
            if (busy && !busy_prev) begin
                rise_count++;
                rise_cyc = cyc;
            end
            if (frame_done) begin
                chk("frame_done_width", 32'(fd_prev), 32'd0);
                fd_count++;
                fd_cyc = cyc;
            end
            busy_prev = busy;
            fd_prev   = frame_done;
        end
    end

    // px_ready driver: 0 = always ready, 1 = pattern 0,0,1, 2 = never ready.
    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: px_ready = 1'b1;
                1: begin
                    px_ready = (bp_ph == 2);
                    bp_ph = (bp_ph + 1) % 3;
                end
                default: px_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_set(input int s, input logic [7:0] b);
        for (int k = 0; k < NP; k++) pix_in[24*k +: 24] = set_tab[s][k];
        bright = b;
    endtask

    task automatic push_exp(input int e);
        for (int k = 0; k < NP; k++) sb_q.push_back(exp_tab[e][k]);
    endtask

    function automatic int cur(input int which);
        case (which)
            0:       return rise_count;
            1:       return fd_count;
            default: return hs_total;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int target, input int budget);
        int n;
        n = 0;
        while (cur(which) < target && n < budget) begin
            step(1);
            n++;
        end
        if (cur(which) < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out after %0d cycles, count %0d required %0d",
                     name, budget, cur(which), target);
        end
    endtask

    task automatic end_frame(input string name, input int hs_base, input int left);
        chk({name, "_sb_left"}, 32'(sb_q.size()), 32'(left));
        chk({name, "_words"}, 32'(hs_total - hs_base), 32'(NP));
    endtask

    initial begin
        int r;
        int ra;
        int hb;
        int x;
        int dg;

        set_tab[0] = '{24'h800000, 24'h00FF00, 24'h0000FF, 24'h123456, 24'h808000, 24'hFFFFFF, 24'h000000};
        set_tab[1] = '{24'h805000, 24'hFF0000, 24'h000001, 24'h0102FF, 24'h805000, 24'h805000, 24'h805000};
        // set 0 at bright 255
        exp_tab[0] = '{24'h008000, 24'hFF0000, 24'h0000FF, 24'h341256, 24'h808000, 24'hFFFFFF, 24'h000000};
        // set 1 at bright 127
        exp_tab[1] = '{24'h284000, 24'h007F00, 24'h000000, 24'h01007F, 24'h284000, 24'h284000, 24'h284000};
        // set 1 at bright 255
        exp_tab[2] = '{24'h508000, 24'h00FF00, 24'h000001, 24'h0201FF, 24'h508000, 24'h508000, 24'h508000};
        // any set at bright 0
        exp_tab[3] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000};

        rst      = 1'b1;
        enable   = 1'b0;
        ser_busy = 1'b0;
        bright   = 8'd0;
        pix_in   = '0;
        step(3);
        chk("rst_px_valid", 32'(px_valid), 32'd0);
        chk("rst_px_data", 32'(px_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Frame A: first tick, bright 255, full-rate handshake.
        apply_set(0, 8'd255);
        push_exp(0);
        enable = 1'b1;
        rst    = 1'b0;
        r      = cyc;
        hb     = hs_total;
        wait_for("A_start", 0, 1, 1100);
        ra = rise_cyc;
        chk("A_start_cycle", 32'(ra), 32'(r + 1000));
        wait_for("A_done", 1, 1, 100);
        chk("A_length", 32'(fd_cyc - ra), 32'd29);
        end_frame("A", hb, 0);

        // Frame B: bright 127, one refresh period later.
        apply_set(1, 8'd127);
        push_exp(1);
        hb = hs_total;
        wait_for("B_start", 0, 2, 1100);
        chk("B_period", 32'(rise_cyc - ra), 32'd1000);
        wait_for("B_done", 1, 2, 100);
        end_frame("B", hb, 0);

        // Frame C: backpressure, inputs changed mid-frame must not tear.
        bp_mode = 1;
        apply_set(0, 8'd255);
        push_exp(0);
        hb = hs_total;
        wait_for("C_start", 0, 3, 1100);
        wait_for("C_mid", 2, hb + 2, 100);
        apply_set(1, 8'd127);
        wait_for("C_done", 1, 3, 200);
        end_frame("C", hb, 0);

        // Frame D: picks up the values changed during C.
        push_exp(1);
        hb = hs_total;
        wait_for("D_start", 0, 4, 1100);
        wait_for("D_done", 1, 4, 200);
        end_frame("D", hb, 0);
        bp_mode = 0;

        // Frame E: bright 0, serializer busy 50 cycles after the last word.
        apply_set(0, 8'd0);
        push_exp(3);
        ser_busy = 1'b1;
        hb = hs_total;
        wait_for("E_start", 0, 5, 1100);
        wait_for("E_words", 2, hb + NP, 100);
        step(50);
        chk("E_drain_busy", 32'(busy), 32'd1);
        chk("E_no_early_done", 32'(fd_count), 32'd4);
        ser_busy = 1'b0;
        x = cyc;
        wait_for("E_done", 1, 5, 100);
        chk("E_latch_after_drain", 32'(fd_cyc - x), 32'd21);
        end_frame("E", hb, 0);

        // Frame F: long drain spans several ticks; G must follow at once.
        apply_set(1, 8'd255);
        push_exp(2);
        ser_busy = 1'b1;
        hb = hs_total;
        wait_for("F_start", 0, 6, 1100);
        wait_for("F_words", 2, hb + NP, 100);
        step(2100);
        push_exp(2);
        ser_busy = 1'b0;
        wait_for("F_done", 1, 6, 100);
        end_frame("F", hb, NP);

        hb = hs_total;
        wait_for("G_start", 0, 7, 10);
        chk("G_pending_start", 32'(rise_cyc), 32'(fd_cyc + 1));
        wait_for("G_done", 1, 7, 100);
        end_frame("G", hb, 0);
        dg = fd_cyc;

        // Frame H: only one pending frame, next start is back on the tick grid.
        push_exp(2);
        hb = hs_total;
        wait_for("H_start", 0, 8, 1100);
        chk("H_not_immediate", 32'(rise_cyc > dg + 1), 32'd1);
        chk("H_phase", 32'((rise_cyc - ra) % 1000), 32'd0);
        enable = 1'b0;
        wait_for("H_done", 1, 8, 100);
        end_frame("H", hb, 0);

        // Disabled across a tick: nothing starts, then pending frame on enable.
        r = rise_count;
        step(1500);
        chk("disabled_no_start", 32'(rise_count), 32'(r));
        chk("disabled_idle", 32'(busy), 32'd0);
        bp_mode = 2;
        push_exp(2);
        enable = 1'b1;
        x = cyc;
        wait_for("I_start", 0, 9, 10);
        chk("I_pending_start", 32'(rise_cyc), 32'(x + 1));
        step(5);
        chk("I_stalled_valid", 32'(px_valid), 32'd1);

        // Asynchronous reset mid-SEND.
        rst = 1'b1;
        #1;
        chk("abort_px_valid", 32'(px_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        sb_q.delete();
        step(2);
        chk("abort_px_data", 32'(px_data), 32'd0);
        rst = 1'b0;
        step(2);
        chk("after_abort_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws_frame_sequencer.md
Name: ws_frame_sequencer

Overview:
Frame scheduler for the ear WS2812 LED chain. It snapshots the per-LED 24-bit colour words at a fixed refresh rate and applies a global brightness scale. It streams one GRB pixel word at a time to the downstream bit serializer over a valid/ready handshake, then holds the line-reset (latch) gap before the next frame. It sits between the colour-generation logic (rgb0..rgb6 producers) and the serializer that drives ws.

Parameters:
NUM_PIX, 7, number of LEDs per chain (1..16)
REFRESH_CYCLES, 400000, clk cycles between refresh ticks (frame period)
LATCH_CYCLES, 1200, clk cycles of idle line after the last pixel (must be >= 50 us at clk rate)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  when low, no new frame starts; a frame in progress completes
pix_in  in  24*NUM_PIX  packed colours; pixel k at [24k+23:24k], each word {R,G,B} 8 bits each
bright  in  8  global brightness, sampled at frame load
px_valid  out  1  pixel word available to serializer
px_data  out  24  pixel word, GRB order {G,R,B}, scaled
px_ready  in  1  serializer accepts px_data this cycle
ser_busy  in  1  serializer still shifting bits
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of latch gap

Behaviour:
- All logic is clocked on the rising edge of clk; rst is asynchronous.
- Reset: state=IDLE, px_valid=0, px_data=0, busy=0, frame_done=0, refresh counter=0, pending=0, pixel index=0, latch counter=0.
- Refresh counter runs freely 0..REFRESH_CYCLES-1 and is independent of enable and state. tick=1 on the cycle it wraps to 0.
- pending sets on a tick when state!=IDLE or enable=0. It clears on entry to LOAD. Multiple missed ticks collapse into one.
- IDLE: go to LOAD when enable=1 and (tick or pending).
- LOAD (1 cycle):
  - snapshot all pix_in words into the internal frame buffer;
  - capture bright;
  - set index=0;
  - px_data <= scale(pix_in[0], bright);
  - px_valid <= 1; next state SEND.
- Scaling: each channel out = (ch * (bright+1)) >> 8, computed in a 16-bit product and truncated to 8 bits. bright=255 gives identity; bright=0 gives 0. Output word order is {G,R,B}.
- SEND:
  - px_valid and px_data hold stable until px_ready=1.
  - Handshake with index<NUM_PIX-1: index++, px_data <= scaled snapshot[index+1], px_valid stays 1. Back-to-back transfers are possible, one per cycle.
  - Handshake with index=NUM_PIX-1: px_valid <= 0, go to DRAIN.
  - Later pix_in or bright changes do not affect the frame in flight (no tearing).
- DRAIN: minimum 1 cycle. Leave for LATCH on the first cycle with ser_busy=0 after entry; clear the latch counter.
- LATCH: count LATCH_CYCLES cycles. On the final count, pulse frame_done=1 for that cycle and go to IDLE.
- enable deasserted mid-frame: ignored until the frame returns to IDLE.
- A tick in the same cycle that LATCH ends sets pending, so the next frame starts from IDLE.
- Reset asserted mid-frame: px_valid drops immediately (asynchronously) and everything returns to reset values. The serializer must tolerate an aborted word.
- Frame length in cycles = 1 (LOAD) + pixel handshake cycles + drain cycles + LATCH_CYCLES.

Test Plan:
- Bench config NUM_PIX=7, REFRESH_CYCLES=1000, LATCH_CYCLES=20, bright=255, px_ready tied 1, ser_busy=0, pixel 0 = 0x800000 -> after the first tick: LOAD, then 7 consecutive px_valid cycles; first px_data=0x008000, pixel 4 (0x808000) -> 0x808000. Then DRAIN (1 cycle), 20 LATCH cycles, frame_done at cycle 1+7+1+20 after the tick.
- bright=127, pixel=0x805000 -> px_data=0x284000 (R 0x80->0x40, G 0x50->0x28). bright=0 -> every px_data=0x000000.
- Backpressure: px_ready toggles 0,0,1 repeatedly -> px_data stable while px_valid=1 and px_ready=0; exactly 7 words transferred, in order.
- Change pix_in and bright during SEND -> the current frame emits the snapshot values; the next frame emits the new ones.
- Hold ser_busy=1 for 50 cycles after the last handshake -> DRAIN lasts until ser_busy falls; the LATCH gap starts only after that.
- Pending ticks and reset:
  - Set REFRESH_CYCLES=20 so several ticks fire during one frame -> a single pending frame starts immediately after IDLE.
  - Hold enable=0 -> no frame starts; after enable=1 the pending frame starts.
  - Assert rst mid-SEND -> px_valid=0 the same cycle; busy=0.
